// File: rtl/timer_capture_if.sv
// Read-side port of the capture FIFO.
// The unit drives the show-ahead head entry; the reader pops with RD_EN.
interface timer_capture_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2
);
  logic [DATA_WIDTH-1:0] DATA;
  logic                  VALID;
  logic [ADDR_WIDTH:0]   LEVEL;
  logic                  RD_EN;

  modport master (
    output DATA,
    output VALID,
    output LEVEL,
    input  RD_EN
  );

  modport slave (
    input  DATA,
    input  VALID,
    input  LEVEL,
    output RD_EN
  );
endinterface

// File: rtl/timer_capture.sv
// Input capture: synchronize EVENT, detect edges,
// and queue TIMER snapshots in a show-ahead FIFO.
module timer_capture #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic [DATA_WIDTH-1:0] TIMER,
  input  logic                  EVENT,
  input  logic [1:0]            EDGE_SEL,
  input  logic                  CLR_OVF,
  output logic                  OVERFLOW,
  timer_capture_if.master       rd
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LVL =
    (ADDR_WIDTH+1)'(DEPTH);

  logic ev_s1, ev_s2, ev_s3;
  logic rise, fall, hit;
  logic wr, pop, push, drop;
  logic empty, full;

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   level;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  ovf;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      ev_s1 <= 1'b0;
      ev_s2 <= 1'b0;
      ev_s3 <= 1'b0;
    end else begin
      ev_s1 <= EVENT;
      ev_s2 <= ev_s1;
      ev_s3 <= ev_s2;
    end
  end

  assign rise = ev_s2 & ~ev_s3;
  assign fall = ~ev_s2 & ev_s3;

  always_comb begin
    hit = 1'b0;
    unique case (EDGE_SEL)
      2'b00: hit = rise;
      2'b01: hit = fall;
      2'b10: hit = rise | fall;
      2'b11: hit = 1'b0;
    endcase
  end

  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);
  assign wr    = hit & ENABLE;
  assign pop   = rd.RD_EN & ~empty;
  // A pop frees the head slot in the same cycle, so full+pop still writes.
  assign push  = wr & (~full | pop);
  assign drop  = wr & full & ~pop;

  always_ff @(posedge CLOCK) begin
    if (push)
      mem[wr_ptr] <= TIMER;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop)
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      unique case ({push, pop})
        2'b10:   level <= level + (ADDR_WIDTH+1)'(1);
        2'b01:   level <= level - (ADDR_WIDTH+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Set has priority over clear so a drop is never lost.
  always_ff @(posedge CLOCK) begin
    if (RESET)
      ovf <= 1'b0;
    else if (drop)
      ovf <= 1'b1;
    else if (CLR_OVF)
      ovf <= 1'b0;
  end

  assign OVERFLOW = ovf;
  assign rd.VALID = ~empty;
  assign rd.LEVEL = level;
  assign rd.DATA  = empty ? '0 : mem[rd_ptr];

endmodule

// File: doc/timer_capture.md
# timer_capture

Input-capture unit that timestamps external events against the free-running timer count. It synchronizes an event line and detects the selected edge(s). On each detected edge it latches the timer value into a small show-ahead FIFO, which a downstream reader drains through a read-enable handshake. It sits beside the timer counter and consumes its count output, so software and FSM logic can measure pulse widths and periods without polling.

## Interface
- DATA_WIDTH, 16, width of the timer value and of each captured timestamp.
- ADDR_WIDTH, 2, FIFO address width; FIFO depth = 2**ADDR_WIDTH (default 4 entries).

- CLOCK  in  1  sole clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  1 = detected edges are captured; 0 = edges ignored. The synchronizer always runs.
- TIMER  in  DATA_WIDTH  current timer count, synchronous to CLOCK.
- EVENT  in  1  asynchronous event line.
- EDGE_SEL  in  2  edge select: 00 = rising, 01 = falling, 10 = both, 11 = none.
- RD_EN  in  1  pops the head entry when VALID=1; ignored when VALID=0.
- CLR_OVF  in  1  clears OVERFLOW.
- DATA  out  DATA_WIDTH  head-of-FIFO timestamp; valid while VALID=1.
- VALID  out  1  FIFO non-empty.
- LEVEL  out  ADDR_WIDTH+1  number of stored entries, range 0..2**ADDR_WIDTH.
- OVERFLOW  out  1  sticky; set when a capture is dropped because the FIFO is full.

## Operation
- Synchronizer: ev_s1 <= EVENT; ev_s2 <= ev_s1; ev_s3 <= ev_s2. All three reset to 0.
- Edge detection:
  - rise = ev_s2 & ~ev_s3
  - fall = ~ev_s2 & ev_s3
  - hit = the rise/fall combination chosen by EDGE_SEL, forced to 0 for EDGE_SEL=11.
- Capture request: wr = hit & ENABLE. The written value is TIMER sampled on the same clock edge as the write.
- FIFO: circular buffer with wr_ptr and rd_ptr of ADDR_WIDTH bits, wrapping modulo depth, plus an occupancy counter that drives LEVEL.
- DATA is the registered or RAM-read head entry, show-ahead: it is valid in the same cycle VALID=1, with no extra read latency.
- Write when full:
  - full and no pop in the same cycle: write is dropped, storage is unchanged, OVERFLOW <= 1.
  - full and RD_EN=1 in the same cycle: pop and write both occur, LEVEL stays at depth, no overflow.
- Read when empty: RD_EN has no effect; pointers and LEVEL are unchanged.
- Simultaneous pop and write at 0 < LEVEL < depth: LEVEL is unchanged.
- OVERFLOW: cleared by CLR_OVF. If a set condition and CLR_OVF occur in the same cycle, set wins.
- EDGE_SEL and ENABLE changes take effect on the next clock edge. They never cause a spurious capture, because ev_s2/ev_s3 keep tracking EVENT while ENABLE=0.
- Reset state:
  - RESET=1 at a clock edge clears ev_s1..ev_s3, both pointers, LEVEL, VALID and OVERFLOW.
  - DATA is 0 after reset.
  - Reset mid-operation discards all stored entries.
- EVENT held high through reset release: with EDGE_SEL rising or both, this is detected as a rising edge two cycles after release and captured if ENABLE=1. This behaviour is intentional and deterministic.

## Timing
- Edge numbering: E0 is the first clock edge at which a new EVENT level is sampled into ev_s1.
  - E1: the new level reaches ev_s2; hit is asserted during the cycle after E1.
  - E2: write occurs, storing TIMER as sampled at E2.
  - VALID rises after E2 if the FIFO was empty.
- If TIMER increments once per clock, the captured value = TIMER at E0 + 2.
- Pop: with RD_EN=1 at edge Ek, the next entry appears on DATA (or VALID falls) after Ek.
- Event spacing: successive same-polarity edges need EVENT stable for at least 1 cycle between transitions to be resolved. Pulses shorter than one cycle may be lost.
- Throughput: one capture per cycle maximum (EDGE_SEL=10 with EVENT toggling every cycle).

## Test plan
- Single rise, empty FIFO: TIMER counts from 0x0100, EVENT rises before E0 when TIMER=0x0100, EDGE_SEL=00, ENABLE=1 -> VALID=1 after E2, DATA=0x0102, LEVEL=1. Then RD_EN for one cycle -> VALID=0, LEVEL=0.
- Both edges: EDGE_SEL=10, EVENT high for 5 cycles, TIMER free-running -> two entries whose difference is 5; LEVEL=2.
- Overflow: depth 4, five rising edges with no reads -> LEVEL=4, OVERFLOW=1, the first four timestamps are retained in order. Full-plus-pop in the same cycle -> no overflow, LEVEL stays 4. CLR_OVF -> OVERFLOW=0; CLR_OVF coincident with a drop -> OVERFLOW stays 1.
- Gating: ENABLE=0 during a rising edge, then ENABLE=1 while EVENT is still high -> no capture. EDGE_SEL=11 -> no captures on any edge.
- Empty read and wrap: RD_EN pulses while empty -> LEVEL stays 0. Ten write/read pairs -> pointer wrap-around, every DATA value matches its TIMER value at the write edge.
- Reset: assert RESET with 3 entries stored and OVERFLOW=1 -> after the edge LEVEL=0, VALID=0, OVERFLOW=0, DATA=0. EVENT held high across reset release with EDGE_SEL=00 -> one capture two cycles after release.
